// File: rtl/icache_pkg.sv
// icache_pkg: shared types and constants for the instruction-cache refill path.
//   refill_state_t : refill FSM state encoding (IDLE, BURST, RETRY, FILL)
//   CTI_*/BTE_*    : Wishbone registered-feedback cycle-type / burst-type codes
//   LINE_*         : cache-line geometry (8 x 32-bit words, 5-bit byte offset)
//   line_base()    : strips the byte offset from an address
package icache_pkg;

  localparam int LINE_WORDS    = 8;
  localparam int LINE_BITS     = 256;
  localparam int OFFSET_BITS   = 5;
  localparam int WORD_IDX_BITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_RETRY = 2'd2,
    ST_FILL  = 2'd3
  } refill_state_t;

  localparam logic [2:0] CTI_INCR   = 3'b010;
  localparam logic [2:0] CTI_EOB    = 3'b111;
  localparam logic [1:0] BTE_LINEAR = 2'b00;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_line_buf.sv
// icache_line_buf: 8 x 32-bit word register file holding the line being refilled.
//   clk, rst_n : clock, synchronous active-low reset (clears every word)
//   we         : write enable for one word this cycle
//   idx        : word index to write (address bits [4:2] of the beat)
//   wdata      : word to store
//   rdata      : whole line, word k at [32k+31:32k]; registered storage, so
//                it holds its contents until a word is overwritten
module icache_line_buf
  import icache_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [WORD_IDX_BITS-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [LINE_BITS-1:0]     rdata
);

  logic [31:0] words [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        words[i] <= '0;
      end
    end else if (we) begin
      words[idx] <= wdata;
    end
  end

  for (genvar k = 0; k < LINE_WORDS; k++) begin : g_flat
    assign rdata[32*k +: 32] = words[k];
  end

endmodule

// File: rtl/icache_refill.sv
// icache_refill: instruction-cache miss refill engine.
// Captures a line-miss address, reads the 32-byte line as an 8-beat Wishbone
// incrementing burst, assembles it and writes it to the cache arrays with a
// single-cycle strobe.
//   clk, rst_n            : clock, synchronous active-low reset
//   miss_req, miss_paddr  : refill request and miss address (sampled in IDLE only)
//   refill_busy           : engine is working on a request
//   line_data, line_we    : assembled line and one-cycle fill strobe
//   refill_err            : one-cycle pulse when a refill is aborted
//   wb_*                  : Wishbone read master (classic + registered burst tags)
//   dbg_state             : current FSM state, for observation only
//
// Bus handshake: a beat is offered while cyc=stb=1, and address/cti stay
// frozen until the slave terminates it. Exactly one termination is honoured
// per cycle with priority err > rty > ack; terminations seen while stb=0 are
// ignored. An ack completes the beat, rty withdraws the strobe for one cycle
// and re-offers the same beat, err abandons the line.
module icache_refill
  import icache_pkg::*;
#(
  parameter int MAX_RETRY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 miss_req,
  input  logic [31:0]          miss_paddr,
  output logic                 refill_busy,
  output logic [LINE_BITS-1:0] line_data,
  output logic                 line_we,
  output logic                 refill_err,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [31:0]          wb_adr_o,
  output logic [3:0]           wb_sel_o,
  output logic [2:0]           wb_cti_o,
  output logic [1:0]           wb_bte_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  input  logic                 wb_rty_i,
  output logic [1:0]           dbg_state
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  // The retry that would bring the count up to MAX_RETRY aborts instead.
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  refill_state_t            state;
  logic [31:0]              base;
  logic [WORD_IDX_BITS-1:0] beat;
  logic [WORD_IDX_BITS-1:0] beat_nxt;
  logic [RW-1:0]            retry_cnt;
  logic                     beat_done;

  assign beat_nxt  = beat + 3'd1;
  assign dbg_state = state;

  // A word is captured only for an ack that wins arbitration on a live strobe.
  assign beat_done = (state == ST_BURST) && wb_ack_i && !wb_err_i && !wb_rty_i;

  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hF;
  assign wb_bte_o = BTE_LINEAR;

  icache_line_buf u_line_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (beat_done),
    .idx   (beat),
    .wdata (wb_dat_i),
    .rdata (line_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      base        <= '0;
      beat        <= '0;
      retry_cnt   <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_adr_o    <= '0;
      wb_cti_o    <= '0;
      line_we     <= 1'b0;
      refill_err  <= 1'b0;
      refill_busy <= 1'b0;
    end else begin
      line_we    <= 1'b0;
      refill_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (miss_req) begin
            base        <= line_base(miss_paddr);
            beat        <= '0;
            retry_cnt   <= '0;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            wb_adr_o    <= line_base(miss_paddr);
            wb_cti_o    <= CTI_INCR;
            refill_busy <= 1'b1;
            state       <= ST_BURST;
          end
        end

        ST_BURST: begin
          if (wb_err_i || (wb_rty_i && retry_cnt == RETRY_LAST)) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            refill_err  <= 1'b1;
            refill_busy <= 1'b0;
            state       <= ST_IDLE;
          end else if (wb_rty_i) begin
            retry_cnt <= retry_cnt + 1'b1;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            state     <= ST_RETRY;
          end else if (wb_ack_i) begin
            retry_cnt <= '0;
            if (beat == 3'd7) begin
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              line_we  <= 1'b1;
              state    <= ST_FILL;
            end else begin
              beat     <= beat_nxt;
              // base is line aligned, so OR-ing in the word offset is an add.
              wb_adr_o <= base | {27'd0, beat_nxt, 2'b00};
              wb_cti_o <= (beat_nxt == 3'd7) ? CTI_EOB : CTI_INCR;
            end
          end
        end

        ST_RETRY: begin
          // Address and cti were left pointing at the unfinished beat.
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          state    <= ST_BURST;
        end

        ST_FILL: begin
          refill_busy <= 1'b0;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: self-checking bench for icache_refill.
// A scripted Wishbone slave answers each beat (wait states, rty, err, reset)
// while a line-level model predicts beat addresses, the assembled line, the
// outcome of the refill and the cycle on which the fill strobe appears.
module tb_icache_refill;
  import icache_pkg::*;

  localparam int MAX_RETRY = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 miss_req;
  logic [31:0]          miss_paddr;
  logic                 refill_busy;
  logic [LINE_BITS-1:0] line_data;
  logic                 line_we;
  logic                 refill_err;
  logic                 wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]          wb_adr_o;
  logic [3:0]           wb_sel_o;
  logic [2:0]           wb_cti_o;
  logic [1:0]           wb_bte_o;
  logic [31:0]          wb_dat_i;
  logic                 wb_ack_i, wb_err_i, wb_rty_i;
  logic [1:0]           dbg_state;

  icache_refill #(.MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_paddr(miss_paddr),
    .refill_busy(refill_busy), .line_data(line_data), .line_we(line_we),
    .refill_err(refill_err), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];        // expected beat addresses still to be acked
  logic [31:0] exp_line [8];    // expected line contents

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pack_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = exp_line[k];
    return l;
  endfunction

  // ---------------- scenario (slave script) ----------------
  int          wait_n [8];
  int          rty_beat, rty_times, err_beat, rst_beat;
  bit          err_ack, hold_req;
  logic [31:0] dseed;

  // Memory contents: word at line offset k reads dseed + k.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return dseed + {29'd0, a[4:2]};
  endfunction

  task automatic set_plain();
    for (int k = 0; k < 8; k++) wait_n[k] = 0;
    rty_beat = -1; rty_times = 0; err_beat = -1; err_ack = 1'b0;
    rst_beat = -1; hold_req = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Issues one request and plays the slave until fill, abort or reset.
  // gap = number of clock edges from raising miss_req to the capture edge.
  task automatic run_refill(input logic [31:0] paddr, output int gap);
    logic [31:0] base;
    int beat, rty_left, wleft, cyc_n, exp_cycle, outcome, exp_outcome;
    bit prev_rty, prev2_rty;

    base = {paddr[31:5], 5'd0};
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(base + 32'(4 * k));
      exp_line[k] = mem_rd(base + 32'(4 * k));
    end
    if (rst_beat >= 0)                                 exp_outcome = 2;
    else if (err_beat >= 0 || rty_times >= MAX_RETRY) exp_outcome = 1;
    else                                               exp_outcome = 0;
    // Cycle 1 follows the capture edge. Eight acks plus the fill cycle give 9;
    // every slave wait adds one, and each retry costs its rty-terminated
    // strobe cycle plus the idle cycle with the strobe withdrawn.
    exp_cycle = 9 + 2 * rty_times;
    for (int k = 0; k < 8; k++) exp_cycle += wait_n[k];

    miss_req   = 1'b1;
    miss_paddr = paddr;
    gap = 0;
    do begin
      @(posedge clk); @(negedge clk); gap++;
    end while (!refill_busy && gap < 8);
    check("capture_busy", refill_busy, 1'b1);
    if (!hold_req) miss_req = 1'b0;

    beat = 0; rty_left = rty_times; wleft = wait_n[0]; cyc_n = 1;
    prev_rty = 1'b0; prev2_rty = 1'b0; outcome = 3;
    while (outcome == 3 && cyc_n < 300) begin
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      if (prev_rty)  check("retry_idle", {wb_cyc_o, wb_stb_o}, 2'b00);
      if (prev2_rty) check("retry_reissue", wb_stb_o, 1'b1);
      prev2_rty = prev_rty;
      prev_rty  = 1'b0;
      if (line_we) begin
        check("fill_cycle", cyc_n, exp_cycle);
        check("fill_cyc_low", wb_cyc_o, 1'b0);
        check("fill_data", line_data, pack_line());
        check("fill_beats", beat, 8);
        outcome = 0;
      end else if (refill_err) begin
        check("abort_busy", refill_busy, 1'b0);
        check("abort_cyc", wb_cyc_o, 1'b0);
        outcome = 1;
      end else if (wb_stb_o) begin
        check("cyc_with_stb", wb_cyc_o, 1'b1);
        check("adr", wb_adr_o, (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF);
        check("cti", wb_cti_o, (beat == 7) ? CTI_EOB : CTI_INCR);
        if (beat == rst_beat) begin
          rst_n = 1'b0;
          @(posedge clk); @(negedge clk);
          check("rst_mid_ctrl", {wb_cyc_o, wb_stb_o, wb_adr_o, wb_cti_o,
                                 line_we, refill_err, refill_busy}, '0);
          check("rst_mid_line", line_data, '0);
          rst_n = 1'b1;
          outcome = 2;
        end else if (wleft > 0) begin
          wleft--;
        end else if (beat == err_beat) begin
          wb_err_i = 1'b1;
          wb_ack_i = err_ack;
          wb_dat_i = mem_rd(exp_q[0]);
        end else if (beat == rty_beat && rty_left > 0) begin
          wb_rty_i = 1'b1;
          rty_left--;
          prev_rty = 1'b1;
        end else begin
          wb_ack_i = 1'b1;
          wb_dat_i = mem_rd(exp_q[0]);
          void'(exp_q.pop_front());
          beat++;
          if (beat < 8) wleft = wait_n[beat];
        end
      end
      if (outcome == 3) begin
        @(posedge clk); @(negedge clk); cyc_n++;
      end
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    check("outcome", outcome, exp_outcome);
    if (outcome == 1 && !hold_req) begin
      @(posedge clk); @(negedge clk);
      check("no_fill_after_abort", {line_we, refill_err, refill_busy}, 3'b000);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int gap;
    rst_n = 1'b0; miss_req = 1'b0; miss_paddr = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    dseed = '0;
    set_plain();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {wb_cyc_o, wb_stb_o, wb_adr_o, wb_cti_o,
                       line_we, refill_err, refill_busy}, '0);
    check("rst_line", line_data, '0);
    check("rst_state", dbg_state, ST_IDLE);
    check("const_sel", wb_sel_o, 4'hF);
    check("const_bte", wb_bte_o, 2'b00);
    check("const_we", wb_we_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait burst with the reference address and data pattern.
    set_plain(); dseed = 32'hA000_0000;
    run_refill(32'h0000_1234, gap);
    repeat (3) @(negedge clk);
    check("line_hold", line_data, pack_line());

    // Two wait states before every ack: fill on cycle 25.
    set_plain(); dseed = $urandom;
    for (int k = 0; k < 8; k++) wait_n[k] = 2;
    run_refill($urandom, gap);

    // One retry on beat 3.
    set_plain(); dseed = $urandom; rty_beat = 3; rty_times = 1;
    run_refill(32'h0000_8000, gap);

    // Retry exhaustion on beat 0.
    set_plain(); dseed = $urandom; rty_beat = 0; rty_times = 4;
    run_refill(32'h0000_4020, gap);

    // err together with ack on beat 5, request held throughout; the held
    // request must start a fresh refill only once the engine is idle.
    set_plain(); dseed = $urandom; err_beat = 5; err_ack = 1'b1; hold_req = 1'b1;
    run_refill(32'h0001_0040, gap);
    set_plain(); dseed = $urandom;
    run_refill(32'h0001_0040, gap);
    check("held_req_gap", gap, 1);

    // Reset during beat 4, then a clean refill.
    set_plain(); dseed = $urandom; rst_beat = 4;
    run_refill(32'h0002_00A0, gap);
    set_plain(); dseed = $urandom;
    run_refill(32'h0002_00A0, gap);

    // Back-to-back refills: request raised during the fill cycle.
    set_plain(); dseed = $urandom;
    run_refill(32'h0003_0000, gap);
    dseed = $urandom;
    run_refill(32'h0003_0020, gap);
    check("b2b_gap", gap, 2);

    // Randomized traffic.
    for (int n = 0; n < 16; n++) begin
      set_plain();
      dseed = $urandom;
      for (int k = 0; k < 8; k++) wait_n[k] = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        rty_beat  = $urandom_range(0, 7);
        rty_times = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 4) == 0) begin
        err_beat = $urandom_range(0, 7);
        err_ack  = 1'($urandom_range(0, 1));
      end
      run_refill($urandom, gap);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
